// File: rtl/sakebi_crc32_checker.sv
// -----------------------------------------------------------------------------
// sakebi_crc32_checker
//
// Receive-side CRC32 frame checker. Each frame ends with a 4-byte FCS, which
// is the complemented CRC sent MSB byte first. The CRC register runs over
// every byte, FCS included. A good frame leaves the register at the fixed
// residue RESIDUE, so the FCS never has to be extracted and compared.
//
// Payload bytes go through a 4-byte delay line. When the last beat arrives,
// the four bytes still in the line are the FCS and are dropped, so the
// consumer never sees them.
//
// Ports
//   i_clk      rising-edge clock
//   i_rst      synchronous active-high reset
//   i_valid    input byte qualifier (no backpressure, always accepted)
//   i_data     input byte, bit 7 shifted into the CRC first
//   i_last     final FCS byte of the frame (qualified by i_valid)
//   o_valid    o_data holds a payload byte
//   o_data     payload byte with the FCS removed
//   o_last     last payload byte (qualified by o_valid)
//   o_done     one-cycle per-frame status strobe
//   o_crc_ok   residue matched and frame not a runt (while o_done)
//   o_runt     frame shorter than MIN_LEN bytes (while o_done)
//   o_len      total bytes received including FCS, saturating (while o_done)
// -----------------------------------------------------------------------------
module sakebi_crc32_checker #(
  parameter int unsigned          DATA_WIDTH = 8,
  parameter int unsigned          CRC_WIDTH  = 32,
  parameter logic [CRC_WIDTH-1:0] CRC        = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0] RESIDUE    = 32'hC704DD7B,
  parameter int unsigned          MIN_LEN    = 5,
  parameter int unsigned          CNT_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_done,
  output logic                  o_crc_ok,
  output logic                  o_runt,
  output logic [CNT_WIDTH-1:0]  o_len
);

  localparam int unsigned DL_DEPTH = 4;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  // One byte of the serial MSB-first CRC, unrolled into one combinational step.
  function automatic logic [CRC_WIDTH-1:0] crc_byte(
    input logic [CRC_WIDTH-1:0]  crc_in,
    input logic [DATA_WIDTH-1:0] data_in
  );
    logic [CRC_WIDTH-1:0]  r;
    logic [DATA_WIDTH-1:0] d;
    logic                  fb;
    r = crc_in;
    d = data_in;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      fb = r[CRC_WIDTH-1] ^ d[DATA_WIDTH-1];
      r  = {r[CRC_WIDTH-2:0], 1'b0} ^ (fb ? CRC : '0);
      d  = {d[DATA_WIDTH-2:0], 1'b0};
    end
    return r;
  endfunction

  // Frame state
  state_e                state_q, state_d;
  logic [CRC_WIDTH-1:0]  crc_q, crc_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  // Delay line: index 0 is the newest byte and index 3 the oldest.
  logic [DATA_WIDTH-1:0] dl_q [DL_DEPTH];
  logic [DATA_WIDTH-1:0] dl_d [DL_DEPTH];
  logic [2:0]            occ_q, occ_d;

  // Registered outputs
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_last_q, o_last_d;
  logic                  o_done_q, o_done_d;
  logic                  o_crc_ok_q, o_crc_ok_d;
  logic                  o_runt_q, o_runt_d;
  logic [CNT_WIDTH-1:0]  o_len_q, o_len_d;

  // Values for the byte on the input this cycle
  logic [CRC_WIDTH-1:0]  crc_base;
  logic [CNT_WIDTH-1:0]  cnt_base;
  logic [CRC_WIDTH-1:0]  crc_upd;
  logic [CNT_WIDTH-1:0]  cnt_upd;
  logic                  runt_upd;
  logic                  dl_full;

  always_comb begin
    // The first byte of a frame always starts from a fresh seed and a zero
    // count. This holds even if a stale value were somehow in the registers.
    crc_base = (state_q == ST_IDLE) ? '1 : crc_q;
    cnt_base = (state_q == ST_IDLE) ? '0 : cnt_q;
    crc_upd  = crc_byte(crc_base, i_data);
    cnt_upd  = (cnt_base == '1) ? cnt_base : cnt_base + 1'b1;
    runt_upd = (cnt_upd < CNT_WIDTH'(MIN_LEN));
    dl_full  = (occ_q == 3'(DL_DEPTH));
  end

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    cnt_d      = cnt_q;
    occ_d      = occ_q;
    dl_d       = dl_q;
    o_valid_d  = 1'b0;
    o_data_d   = o_data_q;
    o_last_d   = 1'b0;
    o_done_d   = 1'b0;
    o_crc_ok_d = 1'b0;
    o_runt_d   = 1'b0;
    o_len_d    = o_len_q;

    if (i_valid) begin
      // A full line means the oldest byte is known to be payload. Four newer
      // bytes sit behind it, so it cannot be part of the FCS.
      if (dl_full) begin
        o_valid_d = 1'b1;
        o_data_d  = dl_q[DL_DEPTH-1];
        o_last_d  = i_last;
      end
      for (int unsigned i = DL_DEPTH - 1; i > 0; i--) begin
        dl_d[i] = dl_q[i-1];
      end
      dl_d[0] = i_data;

      if (i_last) begin
        // End of frame. Re-seed now so a first byte on the very next cycle
        // starts clean. The bytes left in the line are the FCS and are dropped.
        state_d    = ST_IDLE;
        crc_d      = '1;
        cnt_d      = '0;
        occ_d      = '0;
        o_done_d   = 1'b1;
        o_len_d    = cnt_upd;
        o_runt_d   = runt_upd;
        o_crc_ok_d = !runt_upd && (crc_upd == RESIDUE);
      end else begin
        state_d = ST_RUN;
        crc_d   = crc_upd;
        cnt_d   = cnt_upd;
        occ_d   = dl_full ? occ_q : occ_q + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      crc_q      <= '1;
      cnt_q      <= '0;
      occ_q      <= '0;
      for (int unsigned i = 0; i < DL_DEPTH; i++) begin
        dl_q[i] <= '0;
      end
      o_valid_q  <= 1'b0;
      o_data_q   <= '0;
      o_last_q   <= 1'b0;
      o_done_q   <= 1'b0;
      o_crc_ok_q <= 1'b0;
      o_runt_q   <= 1'b0;
      o_len_q    <= '0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      cnt_q      <= cnt_d;
      occ_q      <= occ_d;
      dl_q       <= dl_d;
      o_valid_q  <= o_valid_d;
      o_data_q   <= o_data_d;
      o_last_q   <= o_last_d;
      o_done_q   <= o_done_d;
      o_crc_ok_q <= o_crc_ok_d;
      o_runt_q   <= o_runt_d;
      o_len_q    <= o_len_d;
    end
  end

  assign o_valid  = o_valid_q;
  assign o_data   = o_data_q;
  assign o_last   = o_last_q;
  assign o_done   = o_done_q;
  assign o_crc_ok = o_crc_ok_q;
  assign o_runt   = o_runt_q;
  assign o_len    = o_len_q;

endmodule

// File: tb/tb_sakebi_crc32_checker.sv
// -----------------------------------------------------------------------------
// tb_sakebi_crc32_checker
//
// Scoreboard bench for sakebi_crc32_checker. The stimulus pushes the expected
// payload bytes and frame status, each stamped with the cycle it must appear
// in. A separate monitor on the falling edge pops and compares them whenever
// the DUT raises o_valid or o_done.
// -----------------------------------------------------------------------------
module tb_sakebi_crc32_checker;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [7:0]  i_data;
  logic        i_last;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_last;
  logic        o_done;
  logic        o_crc_ok;
  logic        o_runt;
  logic [15:0] o_len;

  always #5 clk = ~clk;

  sakebi_crc32_checker #(
    .DATA_WIDTH (8),
    .CRC_WIDTH  (32),
    .CRC        (32'h04C11DB7),
    .RESIDUE    (32'hC704DD7B),
    .MIN_LEN    (5),
    .CNT_WIDTH  (16)
  ) dut (
    .i_clk    (clk),
    .i_rst    (i_rst),
    .i_valid  (i_valid),
    .i_data   (i_data),
    .i_last   (i_last),
    .o_valid  (o_valid),
    .o_data   (o_data),
    .o_last   (o_last),
    .o_done   (o_done),
    .o_crc_ok (o_crc_ok),
    .o_runt   (o_runt),
    .o_len    (o_len)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass   = 0;
  int n_checks = 0;

  typedef struct {
    logic [7:0] d;
    logic       last;
    int         cyc;
  } pay_t;

  typedef struct {
    logic        ok;
    logic        runt;
    logic [15:0] len;
    int          cyc;
  } st_t;

  typedef logic [7:0] bytes_t [$];

  pay_t pay_q [$];
  st_t  st_q  [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      i_valid = 1'b0;
      i_last  = 1'b0;
      i_data  = 8'h00;
    end
  endtask

  // Sends the first n_send bytes of a frame. The last byte carries i_last only
  // when the whole frame is sent. Expected outputs are queued at the moment
  // each byte is driven: payload byte j-4 is due one cycle after byte j is
  // accepted, and the status is due one cycle after the last beat.
  task automatic send_frame(input bytes_t b, input logic exp_ok, input bit gaps, input int n_send);
    logic last;
    for (int j = 0; j < n_send; j++) begin
      if (gaps && j > 0 && $urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
      last = (j == b.size() - 1);
      @(posedge clk); #1;
      i_valid = 1'b1;
      i_data  = b[j];
      i_last  = last;
      if (j >= 4) pay_q.push_back('{d: b[j-4], last: last, cyc: cyc + 1});
      if (last) st_q.push_back('{ok: exp_ok, runt: (b.size() < 5), len: 16'(b.size()), cyc: cyc + 1});
    end
  endtask

  // Monitor
  always @(negedge clk) begin
    pay_t pe;
    st_t  se;
    if (o_valid) begin
      if (pay_q.size() == 0) begin
        check("unexpected_payload", 32'(o_valid), 32'd0);
      end else begin
        pe = pay_q.pop_front();
        check("pay_data", 32'(o_data), 32'(pe.d));
        check("pay_last", 32'(o_last), 32'(pe.last));
        check("pay_cycle", 32'(cyc), 32'(pe.cyc));
      end
    end
    if (o_done) begin
      if (st_q.size() == 0) begin
        check("unexpected_done", 32'(o_done), 32'd0);
      end else begin
        se = st_q.pop_front();
        check("st_crc_ok", 32'(o_crc_ok), 32'(se.ok));
        check("st_runt", 32'(o_runt), 32'(se.runt));
        check("st_len", 32'(o_len), 32'(se.len));
        check("st_cycle", 32'(cyc), 32'(se.cyc));
      end
    end else begin
      check("crc_ok_without_done", 32'(o_crc_ok), 32'd0);
      check("runt_without_done", 32'(o_runt), 32'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bytes_t good, bad, runt3, runt1;
    good  = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
              8'hFC, 8'h89, 8'h19, 8'h18};
    bad   = good;
    bad[4] = 8'h34;
    runt3 = '{8'hAA, 8'hBB, 8'hCC};
    runt1 = '{8'h5A};

    i_rst   = 1'b1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_data  = 8'h00;
    repeat (3) @(posedge clk);
    #1 i_rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_last", 32'(o_last), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_len", 32'(o_len), 32'd0);

    // Good frame, contiguous
    send_frame(good, 1'b1, 1'b0, good.size());
    idle(3);
    // Single corrupted payload byte
    send_frame(bad, 1'b0, 1'b0, bad.size());
    idle(3);
    // Runts
    send_frame(runt3, 1'b0, 1'b0, runt3.size());
    idle(2);
    send_frame(runt1, 1'b0, 1'b0, runt1.size());
    idle(2);
    // Gapped good frame
    send_frame(good, 1'b1, 1'b1, good.size());
    idle(3);
    // Reset after the 6th byte: the frame is discarded and gives no status
    send_frame(good, 1'b1, 1'b0, 6);
    @(posedge clk); #1;
    i_valid = 1'b0;
    i_last  = 1'b0;
    i_rst   = 1'b1;
    @(posedge clk); #1;
    i_rst   = 1'b0;
    send_frame(good, 1'b1, 1'b0, good.size());
    idle(3);
    // Back-to-back frames
    send_frame(good, 1'b1, 1'b0, good.size());
    send_frame(bad, 1'b0, 1'b0, bad.size());
    idle(6);

    @(negedge clk);
    check("payload_left", 32'(pay_q.size()), 32'd0);
    check("status_left", 32'(st_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
